// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM pipeline stage and the data memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    // Pipeline side: issues requests, consumes responses and the stall flag
    modport master (
        output req_valid, req_rw, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    // Memory side: accepts requests, produces responses and the stall flag
    modport slave (
        input  req_valid, req_rw, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory with a fixed number of wait states
// between request acceptance and a one-cycle response pulse.
module data_mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 256
) (
    input  logic                 CLK,
    input  logic                 CLR,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;

    logic            r_rw;
    logic [1:0]      r_size;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_err;
    logic [31:0]     r_rdata;

    logic [7:0]      r_mem [DEPTH];

    logic            w_ready;
    logic            w_accept;
    logic            w_enter_resp;
    logic            w_rw;
    logic [1:0]      w_size;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic            w_err;
    logic [AW-1:0]   w_idx0;
    logic [AW-1:0]   w_idx1;
    logic [AW-1:0]   w_idx2;
    logic [AW-1:0]   w_idx3;
    logic [31:0]     w_load;

    assign w_ready  = (r_state == ST_IDLE) && CLR;
    assign w_accept = bus.req_valid && w_ready;

    // With zero wait states the RESP-entry edge is the acceptance edge, so use live inputs there
    assign w_rw    = (r_state == ST_IDLE) ? bus.req_rw    : r_rw;
    assign w_size  = (r_state == ST_IDLE) ? bus.req_size  : r_size;
    assign w_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

    assign w_err = (w_size == 2'b11)
                || ((w_size == SZ_HALF) && w_addr[0])
                || ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00));

    assign w_idx0 = AW'(w_addr % DEPTH);
    assign w_idx1 = AW'((32'(w_idx0) + 32'd1) % DEPTH);
    assign w_idx2 = AW'((32'(w_idx0) + 32'd2) % DEPTH);
    assign w_idx3 = AW'((32'(w_idx0) + 32'd3) % DEPTH);

    // Big-endian, zero-extended load data for the current access
    always_comb begin
        w_load = '0;
        case (w_size)
            SZ_BYTE: w_load = {24'd0, r_mem[w_idx0]};
            SZ_HALF: w_load = {16'd0, r_mem[w_idx0], r_mem[w_idx1]};
            SZ_WORD: w_load = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
            default: w_load = '0;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state and wait counter logic
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);

    // Request capture at acceptance; held until the next acceptance
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_rw    <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_rw    <= bus.req_rw;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    // Response registers: loaded on RESP entry, error flag cleared when leaving RESP
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_rw) ? 32'd0 : w_load;
        end else if (r_state == ST_RESP) begin
            r_err   <= 1'b0;
        end
    end

    // Storage commit on RESP entry; contents survive reset
    always_ff @(posedge CLK) begin
        if (w_enter_resp && w_rw && !w_err) begin
            case (w_size)
                SZ_BYTE: begin
                    r_mem[w_idx0] <= w_wdata[7:0];
                end
                SZ_HALF: begin
                    r_mem[w_idx0] <= w_wdata[15:8];
                    r_mem[w_idx1] <= w_wdata[7:0];
                end
                SZ_WORD: begin
                    r_mem[w_idx0] <= w_wdata[31:24];
                    r_mem[w_idx1] <= w_wdata[23:16];
                    r_mem[w_idx2] <= w_wdata[15:8];
                    r_mem[w_idx3] <= w_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_err   = r_err;
    assign bus.rsp_rdata = r_rdata;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states, one with zero wait states.
`timescale 1ns/1ps
module tb_data_mem_responder;
    logic CLK = 1'b0;
    logic CLR;
    int   total = 0;
    int   bad   = 0;

    data_mem_responder_if bus2();
    data_mem_responder_if bus0();

    data_mem_responder #(.WAIT_CYCLES(2), .DEPTH(256)) u_dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus2)
    );

    data_mem_responder #(.WAIT_CYCLES(0), .DEPTH(256)) u_dut0 (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus0)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one request on the two-wait-state DUT and collect its response
    task automatic do_access(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output logic err, output int lat, output int busy_cnt);
        bit got;
        rdata = '0; err = 1'b0; lat = 0; busy_cnt = 0; got = 1'b0;
        bus2.req_valid = 1'b1;
        bus2.req_rw    = rw;
        bus2.req_size  = size;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        tick();
        bus2.req_valid = 1'b0;
        bus2.req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus2.busy === 1'b1) busy_cnt++;
            if (bus2.rsp_valid === 1'b1) begin
                got   = 1'b1;
                rdata = bus2.rsp_rdata;
                err   = bus2.rsp_err;
            end else begin
                tick();
                lat++;
            end
        end
        if (!got) lat = -1;
        tick();
        if (bus2.busy === 1'b1) busy_cnt++;
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        tick();
        tick();
        total++; if (bus2.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus2.req_ready); end
        total++; if (bus2.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus2.rsp_valid); end
        total++; if (bus2.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus2.rsp_err); end
        total++; if (bus2.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus2.rsp_rdata); end
        total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus2.busy); end
        CLR = 1'b1;
        #1;
        total++; if (bus2.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", bus2.req_ready); end
        total++; if (bus0.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready0: got %b want 1", bus0.req_ready); end
    endtask

    task automatic test_word_store_byte_load();
        logic [31:0] rd; logic er; int lat; int bc;
        do_access(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, er, lat, bc);
        total++; if (lat !== 2) begin bad++; $display("FAIL store_word_latency: got %0d want 2", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL store_word_err: got %b want 0", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_word_rdata: got %h want 0", rd); end
        total++; if (bc !== 3) begin bad++; $display("FAIL store_word_busy: got %0d want 3", bc); end
        do_access(1'b0, 2'b00, 32'h11, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h000000AD) begin bad++; $display("FAIL load_byte_11: got %h want 000000ad", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL load_byte_err: got %b want 0", er); end
        do_access(1'b0, 2'b01, 32'h12, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL load_half_12: got %h want 0000beef", rd); end
        do_access(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_word_10: got %h want deadbeef", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL load_word_latency: got %0d want 2", lat); end
    endtask

    task automatic test_halfword_store();
        logic [31:0] rd; logic er; int lat; int bc;
        do_access(1'b1, 2'b10, 32'h20, 32'h00000000, rd, er, lat, bc);
        do_access(1'b1, 2'b01, 32'h20, 32'hFFFF1234, rd, er, lat, bc);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL store_half_err: got %b want 0", er); end
        total++; if (bc !== 3) begin bad++; $display("FAIL store_half_busy: got %0d want 3", bc); end
        do_access(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h12340000) begin bad++; $display("FAIL load_word_20: got %h want 12340000", rd); end
        total++; if (bc !== 3) begin bad++; $display("FAIL load_word_busy: got %0d want 3", bc); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; int bc;
        do_access(1'b1, 2'b10, 32'h00, 32'h01020304, rd, er, lat, bc);
        do_access(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat, bc);
        do_access(1'b0, 2'b10, 32'h22, 32'h0, rd, er, lat, bc);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_word_err: got %b want 1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_word_rdata: got %h want 0", rd); end
        total++; if (bus2.rsp_err !== 1'b0) begin bad++; $display("FAIL err_after_resp: got %b want 0", bus2.rsp_err); end
        do_access(1'b1, 2'b01, 32'h21, 32'h0000ABCD, rd, er, lat, bc);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_half_err: got %b want 1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_half_rdata: got %h want 0", rd); end
        do_access(1'b1, 2'b11, 32'h00, 32'hFFFFFFFF, rd, er, lat, bc);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL rsvd_size_err: got %b want 1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rsvd_size_rdata: got %h want 0", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL rsvd_size_latency: got %0d want 2", lat); end
        do_access(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h12340000) begin bad++; $display("FAIL err_readback_20: got %h want 12340000", rd); end
        do_access(1'b0, 2'b10, 32'h00, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL err_readback_00: got %h want 01020304", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat; int bc;
        do_access(1'b1, 2'b10, 32'h04, 32'h0A0B0C0D, rd, er, lat, bc);
        do_access(1'b0, 2'b10, 32'h00000104, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h0A0B0C0D) begin bad++; $display("FAIL wrap_word_104: got %h want 0a0b0c0d", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wrap_word_err: got %b want 0", er); end
        do_access(1'b1, 2'b00, 32'h000001FF, 32'h0000005A, rd, er, lat, bc);
        do_access(1'b0, 2'b00, 32'h000000FF, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h0000005A) begin bad++; $display("FAIL wrap_byte_ff: got %h want 0000005a", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int bc; bit seen;
        do_access(1'b1, 2'b10, 32'h40, 32'h11111111, rd, er, lat, bc);
        do_access(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat, bc);
        total++; if (bus2.rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold: got %h want deadbeef", bus2.rsp_rdata); end
        total++; if (bus2.rsp_valid !== 1'b0) begin bad++; $display("FAIL valid_idle: got %b want 0", bus2.rsp_valid); end
        bus2.req_valid = 1'b1;
        bus2.req_rw    = 1'b1;
        bus2.req_size  = 2'b10;
        bus2.req_addr  = 32'h40;
        bus2.req_wdata = 32'hCAFEF00D;
        tick();
        bus2.req_valid = 1'b0;
        total++; if (bus2.busy !== 1'b1) begin bad++; $display("FAIL abort_accepted: got busy %b want 1", bus2.busy); end
        tick();
        CLR = 1'b0;
        #1;
        total++; if (bus2.rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", bus2.rsp_valid); end
        total++; if (bus2.rsp_err !== 1'b0) begin bad++; $display("FAIL abort_err: got %b want 0", bus2.rsp_err); end
        total++; if (bus2.rsp_rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata: got %h want 0", bus2.rsp_rdata); end
        total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus2.busy); end
        total++; if (bus2.req_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", bus2.req_ready); end
        tick();
        #2 CLR = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus2.rsp_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_pulse: got pulse %b want 0", seen); end
        do_access(1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL abort_readback: got %h want 11111111", rd); end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] rd; logic er; int lat; int bc;
        bus2.req_valid = 1'b1;
        bus2.req_rw    = 1'b1;
        bus2.req_size  = 2'b10;
        bus2.req_addr  = 32'h50;
        bus2.req_wdata = 32'h77777777;
        tick();
        bus2.req_valid = 1'b0;
        tick();
        tick();
        total++; if (bus2.rsp_valid !== 1'b1) begin bad++; $display("FAIL resp_before_reset: got %b want 1", bus2.rsp_valid); end
        #2 CLR = 1'b0;
        #1;
        total++; if (bus2.rsp_valid !== 1'b0) begin bad++; $display("FAIL resp_reset_drop: got %b want 0", bus2.rsp_valid); end
        #2 CLR = 1'b1;
        tick();
        do_access(1'b0, 2'b10, 32'h50, 32'h0, rd, er, lat, bc);
        total++; if (rd !== 32'h77777777) begin bad++; $display("FAIL resp_reset_commit: got %h want 77777777", rd); end
    endtask

    task automatic test_back_to_back();
        int   pulses;
        logic exp_v;
        bus0.req_valid = 1'b1;
        bus0.req_rw    = 1'b1;
        bus0.req_size  = 2'b10;
        bus0.req_addr  = 32'h08;
        bus0.req_wdata = 32'h0BADC0DE;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v = (k % 2 == 1);
            total++;
            if (bus0.rsp_valid !== exp_v || bus0.req_ready !== !exp_v || bus0.busy !== exp_v) begin
                bad++;
                $display("FAIL b2b_edge%0d: got valid=%b ready=%b busy=%b want valid=%b ready=%b busy=%b",
                         k, bus0.rsp_valid, bus0.req_ready, bus0.busy, exp_v, !exp_v, exp_v);
            end
            if (bus0.rsp_valid === 1'b1) pulses++;
        end
        bus0.req_valid = 1'b0;
        total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        bus0.req_rw    = 1'b0;
        bus0.req_valid = 1'b1;
        tick();
        bus0.req_valid = 1'b0;
        total++; if (bus0.rsp_valid !== 1'b1) begin bad++; $display("FAIL w0_load_valid: got %b want 1", bus0.rsp_valid); end
        total++; if (bus0.rsp_rdata !== 32'h0BADC0DE) begin bad++; $display("FAIL w0_load_rdata: got %h want 0badc0de", bus0.rsp_rdata); end
        tick();
        total++; if (bus0.rsp_valid !== 1'b0) begin bad++; $display("FAIL w0_after_resp: got %b want 0", bus0.rsp_valid); end
    endtask

    initial begin
        bus2.req_valid = 1'b0; bus2.req_rw = 1'b0; bus2.req_size = 2'b00;
        bus2.req_addr  = '0;   bus2.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_rw = 1'b0; bus0.req_size = 2'b00;
        bus0.req_addr  = '0;   bus0.req_wdata = '0;
        test_reset();
        test_word_store_byte_load();
        test_halfword_store();
        test_errors();
        test_wrap();
        test_reset_abort();
        test_reset_in_resp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
